// File: rtl/fft8_ctrl_pkg.sv
// Shared types and layout helpers for the 8-point FFT frame sequencer.
// Each point occupies 2*W bits of a packed bus as {imag, real}.
package fft8_ctrl_pkg;

    localparam int N_PTS = 8;
    localparam int IDX_W = 3;

    typedef enum logic [2:0] {
        LOAD    = 3'd0,
        WRITE   = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        UNLOAD  = 3'd4
    } state_t;

    // LSB position of point idx inside a packed {imag,real} bus
    function automatic int point_lsb(input int idx, input int w);
        return idx * 2 * w;
    endfunction

endpackage

// File: rtl/fft8_frame_buffer.sv
// 8-entry complex register file: single-slot write, bulk parallel load,
// synchronous clear and a full packed read bus.
module fft8_frame_buffer
    import fft8_ctrl_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [IDX_W-1:0]       idx,
    input  logic [2*W-1:0]         wdata,
    input  logic                   load_all,
    input  logic [N_PTS*2*W-1:0]   load_bus,
    output logic [N_PTS*2*W-1:0]   rd_bus
);

    logic [2*W-1:0] mem_r [N_PTS];

    // Clear has priority, then bulk load, then single-slot write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_PTS; i++) mem_r[i] <= '0;
        end else if (load_all) begin
            for (int i = 0; i < N_PTS; i++) mem_r[i] <= load_bus[point_lsb(i, W) +: 2*W];
        end else if (we) begin
            mem_r[idx] <= wdata;
        end
    end

    for (genvar g = 0; g < N_PTS; g++) begin : g_rd
        assign rd_bus[point_lsb(g, W) +: 2*W] = mem_r[g];
    end

endmodule

// File: rtl/fft8_frame_sequencer.sv
// Collects 8 complex samples, sequences the FFT core write/start strobes,
// captures the core outputs and replays them as an 8-beat output stream.
module fft8_frame_sequencer
    import fft8_ctrl_pkg::*;
#(
    parameter int W        = 16,
    parameter int CORE_LAT = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [W-1:0]      s_real,
    input  logic [W-1:0]      s_imag,
    output logic [16*W-1:0]   core_in_bus,
    output logic              core_write,
    output logic              core_start,
    input  logic [16*W-1:0]   core_out_bus,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [W-1:0]      m_real,
    output logic [W-1:0]      m_imag,
    output logic [2:0]        m_index,
    output logic              m_last,
    output logic              busy,
    output logic [15:0]       frame_count
);

    localparam logic [3:0] LAT_LAST = 4'(CORE_LAT - 1);

    state_t             state_r;
    logic [IDX_W-1:0]   ld_cnt_r;
    logic [IDX_W-1:0]   un_cnt_r;
    logic [3:0]         lat_cnt_r;
    logic               s_ready_r;
    logic               core_write_r;
    logic               core_start_r;
    logic               m_valid_r;
    logic [W-1:0]       m_real_r;
    logic [W-1:0]       m_imag_r;
    logic               m_last_r;
    logic               busy_r;
    logic [15:0]        frame_count_r;

    logic                 in_we_s;
    logic                 cap_s;
    logic [16*W-1:0]      out_bus_s;
    logic [2*W-1:0]       pts_s [N_PTS];
    logic [IDX_W-1:0]     nxt_idx_s;
    logic [2*W-1:0]       nxt_pt_s;

    assign in_we_s   = s_valid & s_ready_r;
    assign cap_s     = (state_r == CAPTURE);
    assign nxt_idx_s = un_cnt_r + 3'd1;
    assign nxt_pt_s  = pts_s[nxt_idx_s];

    fft8_frame_buffer #(.W(W)) u_in_buf (
        .clk      (CLK),
        .rst      (RST),
        .we       (in_we_s),
        .idx      (ld_cnt_r),
        .wdata    ({s_imag, s_real}),
        .load_all (1'b0),
        .load_bus ({(16*W){1'b0}}),
        .rd_bus   (core_in_bus)
    );

    fft8_frame_buffer #(.W(W)) u_out_buf (
        .clk      (CLK),
        .rst      (RST),
        .we       (1'b0),
        .idx      (3'd0),
        .wdata    ({(2*W){1'b0}}),
        .load_all (cap_s),
        .load_bus (core_out_bus),
        .rd_bus   (out_bus_s)
    );

    for (genvar g = 0; g < N_PTS; g++) begin : g_pt
        assign pts_s[g] = out_bus_s[point_lsb(g, W) +: 2*W];
    end

    // Frame sequencing FSM; every output is a register updated on transitions
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r       <= LOAD;
            ld_cnt_r      <= 3'd0;
            un_cnt_r      <= 3'd0;
            lat_cnt_r     <= 4'd0;
            s_ready_r     <= 1'b1;
            core_write_r  <= 1'b0;
            core_start_r  <= 1'b0;
            m_valid_r     <= 1'b0;
            m_real_r      <= '0;
            m_imag_r      <= '0;
            m_last_r      <= 1'b0;
            busy_r        <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            case (state_r)
                LOAD: begin
                    if (in_we_s) begin
                        busy_r <= 1'b1;
                        if (ld_cnt_r == 3'd7) begin
                            ld_cnt_r     <= 3'd0;
                            s_ready_r    <= 1'b0;
                            core_write_r <= 1'b1;
                            state_r      <= WRITE;
                        end else begin
                            ld_cnt_r <= ld_cnt_r + 3'd1;
                        end
                    end
                end
                WRITE: begin
                    core_write_r <= 1'b0;
                    core_start_r <= 1'b1;
                    lat_cnt_r    <= 4'd0;
                    state_r      <= RUN;
                end
                RUN: begin
                    if (lat_cnt_r == LAT_LAST) begin
                        core_start_r <= 1'b0;
                        lat_cnt_r    <= 4'd0;
                        state_r      <= CAPTURE;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + 4'd1;
                    end
                end
                CAPTURE: begin
                    // Bin 0 comes straight off the core bus; the buffer loads on this same edge
                    m_valid_r <= 1'b1;
                    m_real_r  <= core_out_bus[W-1:0];
                    m_imag_r  <= core_out_bus[2*W-1:W];
                    m_last_r  <= 1'b0;
                    un_cnt_r  <= 3'd0;
                    state_r   <= UNLOAD;
                end
                UNLOAD: begin
                    if (m_ready) begin
                        if (un_cnt_r == 3'd7) begin
                            m_valid_r     <= 1'b0;
                            m_real_r      <= '0;
                            m_imag_r      <= '0;
                            m_last_r      <= 1'b0;
                            un_cnt_r      <= 3'd0;
                            frame_count_r <= frame_count_r + 16'd1;
                            busy_r        <= 1'b0;
                            s_ready_r     <= 1'b1;
                            state_r       <= LOAD;
                        end else begin
                            un_cnt_r <= nxt_idx_s;
                            m_real_r <= nxt_pt_s[W-1:0];
                            m_imag_r <= nxt_pt_s[2*W-1:W];
                            m_last_r <= (nxt_idx_s == 3'd7);
                        end
                    end
                end
                default: begin
                    state_r      <= LOAD;
                    ld_cnt_r     <= 3'd0;
                    un_cnt_r     <= 3'd0;
                    lat_cnt_r    <= 4'd0;
                    s_ready_r    <= 1'b1;
                    core_write_r <= 1'b0;
                    core_start_r <= 1'b0;
                    m_valid_r    <= 1'b0;
                    m_last_r     <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready     = s_ready_r;
    assign core_write  = core_write_r;
    assign core_start  = core_start_r;
    assign m_valid     = m_valid_r;
    assign m_real      = m_real_r;
    assign m_imag      = m_imag_r;
    assign m_index     = un_cnt_r;
    assign m_last      = m_last_r;
    assign busy        = busy_r;
    assign frame_count = frame_count_r;

endmodule
